token_dispatcher: RTL and testbench

- Sequences the parser array of the snappy decompressor.
- Pops preparsed tokens from the token FIFO and hands each to one of NUM_PARSER parsers, choosing by round-robin among parsers that report ready.
- Counts dispatched tokens and signals page dispatch completion downstream, i.e. to the page-finish controller.
- Sits between the token FIFO and the parser bank.

---
 rtl/token_dispatcher_pkg.sv | 14 +
 rtl/token_dispatcher_if.sv | 26 ++
 rtl/token_dispatcher_rr_arbiter.sv | 31 +++
 rtl/token_dispatcher.sv | 133 +++++++++++++
 tb/tb_token_dispatcher.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/token_dispatcher_pkg.sv
// Shared types and defaults for the snappy decompressor token dispatcher.
package token_dispatcher_pkg;

  localparam int unsigned DEF_NUM_PARSER = 6;
  localparam int unsigned DEF_TOKEN_W    = 128;
  localparam int unsigned DEF_CNT_W      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/token_dispatcher_if.sv
// Token FIFO read side plus parser-bank write side seen by the dispatcher.
interface token_dispatcher_if
  import token_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_PARSER = DEF_NUM_PARSER,
  parameter int unsigned TOKEN_W    = DEF_TOKEN_W
) ();

  logic                  tf_empty;
  logic [TOKEN_W-1:0]    tf_dout;
  logic                  tf_rd_en;
  logic [NUM_PARSER-1:0] ps_ready;
  logic [NUM_PARSER-1:0] ps_wr;
  logic [TOKEN_W-1:0]    ps_din;

  modport master (
    input  tf_empty, tf_dout, ps_ready,
    output tf_rd_en, ps_wr, ps_din
  );

  modport slave (
    output tf_empty, tf_dout, ps_ready,
    input  tf_rd_en, ps_wr, ps_din
  );

endinterface

// File: rtl/token_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  int unsigned scan;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    scan        = 0;
    for (int unsigned i = 0; i < N; i++) begin
      scan = 32'(ptr) + i;
      if (scan >= N) scan = scan - N;
      if (!grant_valid && req[IDX_W'(scan)]) begin
        grant_valid             = 1'b1;
        grant[IDX_W'(scan)]     = 1'b1;
        grant_idx               = IDX_W'(scan);
      end
    end
  end

endmodule

// File: rtl/token_dispatcher.sv
// Pops tokens from the FWFT token FIFO and deals them round-robin to ready parsers.
module token_dispatcher
  import token_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_PARSER = DEF_NUM_PARSER,
  parameter int unsigned TOKEN_W    = DEF_TOKEN_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               page_input_finish,
  token_dispatcher_if.master bus,
  output logic [CNT_W-1:0]   dispatch_cnt,
  output logic               busy,
  output logic               dispatch_done
);

  localparam int unsigned IDX_W = $clog2(NUM_PARSER);

  state_t                state, state_nxt;
  logic                  hold_valid;
  logic [TOKEN_W-1:0]    hold_data;
  logic [IDX_W-1:0]      rr_ptr;
  logic                  fin_flag;

  logic [NUM_PARSER-1:0] arb_req;
  logic [NUM_PARSER-1:0] grant_oh;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  in_run;
  logic                  grant_valid;
  logic                  pop;
  logic                  accept_start;
  logic [IDX_W-1:0]      rr_ptr_nxt;

  logic [NUM_PARSER-1:0] ps_wr_d;
  logic                  busy_d;
  logic                  done_d;

  // Only a held token may compete for a parser
  assign arb_req = hold_valid ? bus.ps_ready : '0;

  rr_arbiter #(.N(NUM_PARSER)) u_arb (
    .req         (arb_req),
    .ptr         (rr_ptr),
    .grant       (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_any)
  );

  assign in_run       = (state == RUN);
  assign accept_start = (state == IDLE) && start;
  assign grant_valid  = in_run && grant_any;
  // Refill the holding register whenever it is empty or being emptied this cycle
  assign pop          = in_run && !bus.tf_empty && (!hold_valid || grant_valid);
  assign bus.tf_rd_en = pop;

  assign rr_ptr_nxt = (grant_idx == IDX_W'(NUM_PARSER - 1)) ? '0 : grant_idx + IDX_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (fin_flag && bus.tf_empty && !hold_valid && !grant_valid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; busy/done follow the state being entered so they align with it
  always_comb begin
    ps_wr_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (grant_valid) ps_wr_d = grant_oh;
    case (state_nxt)
      RUN:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ps_wr     <= '0;
      bus.ps_din    <= '0;
      dispatch_cnt  <= '0;
      busy          <= 1'b0;
      dispatch_done <= 1'b0;
      rr_ptr        <= '0;
      hold_valid    <= 1'b0;
      hold_data     <= '0;
      fin_flag      <= 1'b0;
    end else begin
      bus.ps_wr     <= ps_wr_d;
      busy          <= busy_d;
      dispatch_done <= done_d;

      if (grant_valid) begin
        bus.ps_din   <= hold_data;
        dispatch_cnt <= dispatch_cnt + CNT_W'(1);
        rr_ptr       <= rr_ptr_nxt;
      end

      if (accept_start) begin
        dispatch_cnt <= '0;
        rr_ptr       <= '0;
        hold_valid   <= 1'b0;
      end

      if (pop) begin
        hold_data  <= bus.tf_dout;
        hold_valid <= 1'b1;
      end else if (grant_valid) begin
        hold_valid <= 1'b0;
      end

      // A finish pulse coinciding with a clear still marks the page finished
      if (page_input_finish)                   fin_flag <= 1'b1;
      else if (accept_start || state == DONE)  fin_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_token_dispatcher.sv
// Directed + randomized bench for token_dispatcher against a queue-based reference model.
module tb_token_dispatcher;

  localparam int unsigned NP = 6;
  localparam int unsigned TW = 128;
  localparam int unsigned CW = 32;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic          page_input_finish;
  logic [CW-1:0] dispatch_cnt;
  logic          busy;
  logic          dispatch_done;

  token_dispatcher_if #(.NUM_PARSER(NP), .TOKEN_W(TW)) bus ();

  token_dispatcher #(.NUM_PARSER(NP), .TOKEN_W(TW), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .page_input_finish (page_input_finish),
    .bus               (bus),
    .dispatch_cnt      (dispatch_cnt),
    .busy              (busy),
    .dispatch_done     (dispatch_done)
  );

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] fifo_q[$];
  logic [TW-1:0] held[$];
  logic [NP-1:0] wr_log[$];
  logic [NP-1:0] got[$];
  int            m_state;
  int            m_ptr;
  logic          m_fin;
  logic [CW-1:0] m_cnt;
  int            done_pulses;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_ready(input logic [NP-1:0] r, input int p);
    int idx;
    for (int k = 0; k < int'(NP); k++) begin
      idx = (p + k) % int'(NP);
      if (((r >> idx) & NP'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic drive_fifo();
    bus.tf_empty = (fifo_q.size() == 0);
    bus.tf_dout  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push_tok();
    logic [TW-1:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    fifo_q.push_back(t);
    drive_fifo();
  endtask

  // One clock: predict from the page rules, let the edge happen, compare at the negedge
  task automatic cyc();
    logic          pop_seen;
    logic [NP-1:0] rdy;
    logic          st;
    logic          pf;
    bit            exp_grant;
    bit            exp_pop;
    bit            fifo_empty_pre;
    bit            held_empty_pre;
    int            state_pre;
    int            idx;
    #1;
    pop_seen       = bus.tf_rd_en;
    rdy            = bus.ps_ready;
    st             = start;
    pf             = page_input_finish;
    state_pre      = m_state;
    fifo_empty_pre = (fifo_q.size() == 0);
    held_empty_pre = (held.size() == 0);
    exp_grant = (m_state == M_RUN) && !held_empty_pre && (rdy != '0);
    exp_pop   = (m_state == M_RUN) && !fifo_empty_pre && (held_empty_pre || exp_grant);
    chk("tf_rd_en", 128'(pop_seen), 128'(exp_pop));
    @(posedge clk);
    @(negedge clk);
    if (exp_grant) begin
      idx = first_ready(rdy, m_ptr);
      chk("ps_wr_grant", 128'(bus.ps_wr), 128'(1) << idx);
      chk("ps_din", 128'(bus.ps_din), 128'(held[0]));
      void'(held.pop_front());
      m_ptr = (idx + 1) % int'(NP);
      m_cnt = m_cnt + 1'b1;
    end else begin
      chk("ps_wr_idle", 128'(bus.ps_wr), 128'(0));
    end
    if (pop_seen && fifo_q.size() > 0) held.push_back(fifo_q.pop_front());
    case (state_pre)
      M_IDLE: if (st) begin m_state = M_RUN; m_cnt = '0; m_ptr = 0; end
      M_RUN:  if (m_fin && fifo_empty_pre && held_empty_pre) m_state = M_DONE;
      default: m_state = M_IDLE;
    endcase
    if (pf) m_fin = 1'b1;
    else if ((state_pre == M_IDLE && st) || state_pre == M_DONE) m_fin = 1'b0;
    chk("busy", 128'(busy), 128'(m_state == M_RUN));
    chk("dispatch_done", 128'(dispatch_done), 128'(m_state == M_DONE));
    chk("dispatch_cnt", 128'(dispatch_cnt), 128'(m_cnt));
    if (dispatch_done) done_pulses++;
    wr_log.push_back(bus.ps_wr);
    start             = 1'b0;
    page_input_finish = 1'b0;
    drive_fifo();
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound; n++) begin
      cyc();
      if (m_state == M_IDLE) break;
    end
    chk("drain_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    page_input_finish = 1'b0;
    bus.ps_ready = '0;
    m_state = M_IDLE;
    m_ptr = 0;
    m_cnt = '0;
    m_fin = 1'b0;
    done_pulses = 0;
    drive_fifo();
    repeat (2) @(negedge clk);
    chk("rst_ps_wr", 128'(bus.ps_wr), 128'(0));
    chk("rst_ps_din", 128'(bus.ps_din), 128'(0));
    chk("rst_cnt", 128'(dispatch_cnt), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(dispatch_done), 128'(0));
    rst = 1'b0;

    // Full-ready streaming: strict rotation, one token per cycle
    repeat (12) push_tok();
    bus.ps_ready = '1;
    start = 1'b1;
    wr_log.delete();
    repeat (14) cyc();
    for (int i = 0; i < 14; i++)
      chk("t1_order", 128'(wr_log[i]), (i < 2) ? 128'(0) : (128'(1) << ((i - 2) % 6)));
    chk("t1_cnt", 128'(dispatch_cnt), 128'(12));
    page_input_finish = 1'b1;
    drain(20);

    // Sparse ready mask starting from pointer 2
    repeat (2) push_tok();
    start = 1'b1;
    repeat (6) cyc();
    bus.ps_ready = 6'b001010;
    repeat (3) push_tok();
    wr_log.delete();
    repeat (8) cyc();
    got.delete();
    foreach (wr_log[i]) if (wr_log[i] != '0) got.push_back(wr_log[i]);
    chk("t2_grants", 128'(got.size()), 128'(3));
    if (got.size() == 3) begin
      chk("t2_g0", 128'(got[0]), 128'(6'b001000));
      chk("t2_g1", 128'(got[1]), 128'(6'b000010));
      chk("t2_g2", 128'(got[2]), 128'(6'b001000));
    end
    page_input_finish = 1'b1;
    drain(20);

    // Stall with nothing ready, then release parser 4, then random traffic
    repeat (3) push_tok();
    bus.ps_ready = '0;
    start = 1'b1;
    repeat (21) cyc();
    chk("t3_fifo_left", 128'(fifo_q.size()), 128'(2));
    chk("t3_cnt", 128'(dispatch_cnt), 128'(0));
    bus.ps_ready = 6'b010000;
    cyc();
    chk("t3_grant4", 128'(bus.ps_wr), 128'(6'b010000));
    for (int i = 0; i < 60; i++) begin
      bus.ps_ready = NP'($urandom_range(0, (1 << NP) - 1));
      if ($urandom_range(0, 2) != 0) push_tok();
      cyc();
    end
    page_input_finish = 1'b1;
    bus.ps_ready = '1;
    drain(200);

    // Finish flagged while three tokens are still queued
    repeat (3) push_tok();
    bus.ps_ready = '1;
    start = 1'b1;
    cyc();
    page_input_finish = 1'b1;
    done_pulses = 0;
    repeat (10) cyc();
    chk("t4_done_pulses", 128'(done_pulses), 128'(1));
    chk("t4_cnt", 128'(dispatch_cnt), 128'(3));
    chk("t4_busy", 128'(busy), 128'(0));

    // Start and finish together on an empty FIFO
    start = 1'b1;
    page_input_finish = 1'b1;
    cyc();
    chk("t5_busy1", 128'(busy), 128'(1));
    chk("t5_done1", 128'(dispatch_done), 128'(0));
    cyc();
    chk("t5_done2", 128'(dispatch_done), 128'(1));
    chk("t5_busy2", 128'(busy), 128'(0));
    chk("t5_cnt", 128'(dispatch_cnt), 128'(0));
    cyc();
    chk("t5_done3", 128'(dispatch_done), 128'(0));

    // Asynchronous reset while a token is held
    repeat (3) push_tok();
    bus.ps_ready = 6'b000001;
    start = 1'b1;
    repeat (3) cyc();
    bus.ps_ready = '0;
    cyc();
    chk("t6_cnt_pre", 128'(dispatch_cnt), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_ps_wr", 128'(bus.ps_wr), 128'(0));
    chk("t6_ps_din", 128'(bus.ps_din), 128'(0));
    chk("t6_cnt", 128'(dispatch_cnt), 128'(0));
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_done", 128'(dispatch_done), 128'(0));
    chk("t6_rd_en", 128'(bus.tf_rd_en), 128'(0));
    held.delete();
    m_state = M_IDLE;
    m_ptr = 0;
    m_cnt = '0;
    m_fin = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_fifo_left", 128'(fifo_q.size()), 128'(1));
    bus.ps_ready = '1;
    start = 1'b1;
    wr_log.delete();
    repeat (4) cyc();
    chk("t6_first_grant", 128'(wr_log[2]), 128'(6'b000001));
    chk("t6_cnt_post", 128'(dispatch_cnt), 128'(1));
    page_input_finish = 1'b1;
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
